uart_rx_deserializer: RTL
=========================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit period.
REQ-004 Port clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port rxd  input  1  asynchronous serial line, idle high; frame format 8N1, LSB first.
REQ-007 Port data_out  output  8  last correctly received byte.
REQ-008 Port data_ready  output  1  one-clk pulse when data_out is updated.
REQ-009 Port framing_error  output  1  one-clk pulse when the stop bit samples low.
REQ-010 Port busy  output  1  high from start-edge detect until return to IDLE.

Function
REQ-011 rxd SHALL pass through a 2-FF synchronizer whose flops reset to 1; all logic uses the synchronized value rxs.
REQ-012 Tick generator: TICK_DIV = floor(CLK_FREQ/(BAUD*OVERSAMPLE)), which is 27 at defaults; one-clk tick every TICK_DIV clks.
REQ-013 The tick counter SHALL restart at 0 on start-edge detect so sampling phase aligns to the edge.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: busy=0; a 1->0 transition on rxs SHALL move the FSM to START, clear the sample-tick count and assert busy on the next clk.
REQ-016 START: at sample tick OVERSAMPLE/2 (8), rxs=0 -> DATA with bit index 0; rxs=1 -> IDLE (glitch rejected, no outputs pulsed).
REQ-017 DATA: each bit is the 2-of-3 majority of rxs at ticks 7, 8 and 9 of its 16-tick bit window.
REQ-018 DATA: each decided bit SHALL be shifted into a shift register in LSB-first order; after bit index 7 the FSM SHALL go to STOP.
REQ-019 STOP: the stop bit SHALL be decided by the same majority vote as data bits.
REQ-020 STOP bit=1: data_out <= shift register and data_ready=1 for exactly one clk, then IDLE.
REQ-021 STOP bit=0: framing_error=1 for exactly one clk, data_out unchanged, no data_ready, then WAIT_HIGH.
REQ-022 WAIT_HIGH: remain with busy=1 until rxs=1, then IDLE; a break condition SHALL NOT generate further frames.
REQ-023 A new start edge SHALL be accepted on the first clk after returning to IDLE, supporting back-to-back frames with one stop bit.
REQ-024 data_ready and framing_error SHALL never be high in the same clk.
REQ-025 rxd activity during START/DATA/STOP other than sampled ticks SHALL be ignored.
REQ-026 Latency: data_ready SHALL be asserted 9.5 bit periods +/- 1 tick + 3 clks after the falling edge on rxd.

Reset
REQ-027 While rst=1 at a clk edge: FSM=IDLE, counters=0, shift register=0, data_out=8'h00, data_ready=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no data_ready or framing_error pulse.
REQ-029 After rst deasserts, the next complete valid frame SHALL be received normally.

Verification (CLK_FREQ=50 MHz, BAUD=115200, bench bit period 434 clks)
REQ-030 Frame with 0x4C (01001100), stop=1 -> one data_ready pulse, data_out=8'h4C, framing_error never high, busy low after the stop bit.
REQ-031 Back-to-back frames 0x64 then 0xFF with no idle gap -> two data_ready pulses, data_out=8'h64 then 8'hFF.
REQ-032 Idle line with a 10-clk low glitch -> busy high for under 9 ticks, then low; no data_ready, no framing_error.
REQ-033 Frame 0x00 with stop bit driven 0, line held low 2 bit periods then high -> one framing_error pulse, data_out keeps previous value (8'hFF), busy low only after rxd returns high.
REQ-034 rst pulsed for 2 clks during bit 4 of frame 0xA5, then full frame 0x3C -> outputs zero after reset, single data_ready with data_out=8'h3C.
REQ-035 Frame 0x55 with a 1-clk inverted spike at tick 8 of each data bit -> data_out=8'h55 (majority vote filters the spike).

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// Purpose : 8N1 UART receiver, oversampled with a 2-of-3 majority vote per bit.
// Latency : data_ready about 9.5 bit periods + 1 tick + 3 clk after the rxd falling edge.
// Backpr. : none; the serial line cannot be stalled, so each byte is a one-clk pulse.
//
// Ports:
//   clk           - system clock, all logic on the rising edge
//   rst           - synchronous active-high reset
//   rxd           - asynchronous serial input, idle high
//   data_out      - last byte received with a valid stop bit
//   data_ready    - one-clk pulse when data_out is updated
//   framing_error - one-clk pulse when the stop bit is decided low
//   busy          - high from start-edge detect until the receiver is idle again
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMP_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  // samp_cnt_q holds the number of ticks already seen in the current bit
  // window, so a tick arriving with samp_cnt_q == N is tick N+1 of the window.
  // Votes are taken on ticks MID-1 and MID, and the decision on tick MID+1.
  localparam logic [SMP_W-1:0] SMP_V0  = SMP_W'(OVERSAMPLE / 2 - 2);
  localparam logic [SMP_W-1:0] SMP_V1  = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_DEC = SMP_W'(OVERSAMPLE / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic             rxd_meta_q, rxd_meta_d;
  logic             rxs_q, rxs_d;
  logic             rxs_prev_q, rxs_prev_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       votes_q, votes_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_ready_q, data_ready_d;
  logic             framing_error_q, framing_error_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic [SMP_W-1:0] samp_next;
  logic [1:0]       vote_sum;
  logic             maj;
  logic             fall;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign samp_next = (samp_cnt_q == SMP_LAST) ? '0 : samp_cnt_q + SMP_W'(1);
  // Two earlier votes plus the current sample; 2 or 3 ones sets bit 1.
  assign vote_sum  = votes_q + {1'b0, rxs_q};
  assign maj       = vote_sum[1];
  assign fall      = rxs_prev_q & ~rxs_q;

  always_comb begin
    rxd_meta_d      = rxd;
    rxs_d           = rxd_meta_q;
    rxs_prev_d      = rxs_q;
    state_d         = state_q;
    div_cnt_d       = tick ? '0 : div_cnt_q + DIV_W'(1);
    samp_cnt_d      = samp_cnt_q;
    bit_idx_d       = bit_idx_q;
    votes_d         = votes_q;
    shift_d         = shift_q;
    data_out_d      = data_out_q;
    data_ready_d    = 1'b0;
    framing_error_d = 1'b0;
    busy_d          = busy_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (fall) begin
          // Restart the divider so the tick phase is locked to the edge.
          state_d    = START;
          div_cnt_d  = '0;
          samp_cnt_d = '0;
          votes_d    = '0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          samp_cnt_d = samp_next;
          if (samp_cnt_q == SMP_V1 && rxs_q) begin
            // Line is high again mid start bit: treat as a glitch.
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (samp_cnt_q == SMP_LAST) begin
            // Start bit confirmed; bit 0 window begins on this boundary so
            // every data window is a full OVERSAMPLE ticks.
            state_d   = DATA;
            bit_idx_d = '0;
            votes_d   = '0;
          end
        end
      end

      DATA: begin
        if (tick) begin
          samp_cnt_d = samp_next;
          if (samp_cnt_q == SMP_V0 || samp_cnt_q == SMP_V1) begin
            votes_d = vote_sum;
          end else if (samp_cnt_q == SMP_DEC) begin
            votes_d = '0;
            shift_d = {maj, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end

      STOP: begin
        if (tick) begin
          samp_cnt_d = samp_next;
          if (samp_cnt_q == SMP_V0 || samp_cnt_q == SMP_V1) begin
            votes_d = vote_sum;
          end else if (samp_cnt_q == SMP_DEC) begin
            votes_d = '0;
            if (maj) begin
              // Leave mid stop bit so a back-to-back start edge is caught.
              data_out_d   = shift_q;
              data_ready_d = 1'b1;
              state_d      = IDLE;
              busy_d       = 1'b0;
            end else begin
              framing_error_d = 1'b1;
              state_d         = WAIT_HIGH;
            end
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low (break) line must not be taken as a new start bit.
        if (rxs_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rxd_meta_q      <= 1'b1;
      rxs_q           <= 1'b1;
      rxs_prev_q      <= 1'b1;
      div_cnt_q       <= '0;
      samp_cnt_q      <= '0;
      bit_idx_q       <= '0;
      votes_q         <= '0;
      shift_q         <= '0;
      data_out_q      <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rxd_meta_q      <= rxd_meta_d;
      rxs_q           <= rxs_d;
      rxs_prev_q      <= rxs_prev_d;
      div_cnt_q       <= div_cnt_d;
      samp_cnt_q      <= samp_cnt_d;
      bit_idx_q       <= bit_idx_d;
      votes_q         <= votes_d;
      shift_q         <= shift_d;
      data_out_q      <= data_out_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
      busy_q          <= busy_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign busy          = busy_q;

endmodule
